// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control for the 5-stage core: load-use bubbles, branch squash,
// data-memory freezes and fetch-miss handling, plus saturating stall/flush statistics.
module pipeline_hazard_ctrl #(
    parameter int REG_AW          = 5,
    parameter int LOAD_USE_STALLS = 1,
    parameter int STALL_CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_AW-1:0]      id_rs1,
    input  logic [REG_AW-1:0]      id_rs2,
    input  logic                   id_uses_rs2,
    input  logic                   ex_mem_read,
    input  logic [REG_AW-1:0]      ex_rd,
    input  logic                   ex_branch_taken,
    input  logic                   imem_valid,
    input  logic                   dmem_busy,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ifid_flush,
    output logic                   idex_bubble,
    output logic                   exmem_hold,
    output logic [1:0]             ctrl_state,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [7:0]             flush_count
);

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_LOAD_STALL = 2'd1,
        S_MEM_WAIT   = 2'd2
    } state_t;

    // The first bubble is issued from RUN, so the counter only covers the remainder.
    localparam logic [2:0] BUBBLE_RELOAD = 3'(LOAD_USE_STALLS - 1);

    state_t     state, state_nxt;
    logic [2:0] bub_cnt, bub_cnt_nxt;
    logic       hazard;
    logic       flush_evt;
    logic       eval_run;

    function automatic logic [STALL_CNT_W-1:0] sat_inc_stall(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [7:0] sat_inc_flush(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    assign hazard = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_hold  = 1'b0;
        state_nxt   = state;
        bub_cnt_nxt = bub_cnt;
        flush_evt   = 1'b0;
        eval_run    = 1'b0;

        if (reset) begin
            pc_write    = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_nxt   = S_RUN;
            bub_cnt_nxt = 3'd0;
        end else begin
            case (state)
                S_LOAD_STALL: begin
                    if (ex_branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        flush_evt   = 1'b1;
                        state_nxt   = S_RUN;
                        bub_cnt_nxt = 3'd0;
                    end else if (dmem_busy) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        exmem_hold = 1'b1;
                    end else begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        bub_cnt_nxt = bub_cnt - 3'd1;
                        if (bub_cnt == 3'd1) begin
                            state_nxt = S_RUN;
                        end
                    end
                end
                S_MEM_WAIT: begin
                    if (dmem_busy) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        exmem_hold = 1'b1;
                    end else begin
                        eval_run = 1'b1;
                    end
                end
                default: eval_run = 1'b1;
            endcase

            // Memory released this cycle behaves exactly like RUN.
            if (eval_run) begin
                state_nxt = S_RUN;
                if (ex_branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    flush_evt   = 1'b1;
                end else if (dmem_busy) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    exmem_hold = 1'b1;
                    state_nxt  = S_MEM_WAIT;
                end else if (hazard) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    if (LOAD_USE_STALLS > 1) begin
                        state_nxt   = S_LOAD_STALL;
                        bub_cnt_nxt = BUBBLE_RELOAD;
                    end
                end else if (!imem_valid) begin
                    pc_write   = 1'b0;
                    ifid_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_RUN;
            bub_cnt      <= 3'd0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state   <= state_nxt;
            bub_cnt <= bub_cnt_nxt;
            if (!pc_write) begin
                stall_cycles <= sat_inc_stall(stall_cycles);
            end
            if (flush_evt) begin
                flush_count <= sat_inc_flush(flush_count);
            end
        end
    end

    assign ctrl_state = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (1 and 3 load-use bubbles) checked
// against an integer-based reference model, a vector table and directed corner sequences.
module tb_pipeline_hazard_ctrl;

    localparam int AW = 5;
    localparam logic [4:0] O_RST   = 5'b01110;
    localparam logic [4:0] O_FLUSH = 5'b11110;
    localparam logic [4:0] O_FRZ   = 5'b00001;
    localparam logic [4:0] O_BUB   = 5'b00010;
    localparam logic [4:0] O_MISS  = 5'b01100;
    localparam logic [4:0] O_RUN   = 5'b11000;

    logic clk = 1'b0;
    logic reset;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs2, ex_mem_read, ex_branch_taken, imem_valid, dmem_busy;

    logic a_pcw, a_ifw, a_ifl, a_bub, a_hold;
    logic [1:0] a_st;
    logic [15:0] a_stall;
    logic [7:0] a_fl;
    logic b_pcw, b_ifw, b_ifl, b_bub, b_hold;
    logic [1:0] b_st;
    logic [4:0] b_stall;
    logic [7:0] b_fl;
    logic [4:0] a_o, b_o;

    assign a_o = {a_pcw, a_ifw, a_ifl, a_bub, a_hold};
    assign b_o = {b_pcw, b_ifw, b_ifl, b_bub, b_hold};

    pipeline_hazard_ctrl #(.REG_AW(AW), .LOAD_USE_STALLS(1), .STALL_CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .imem_valid(imem_valid), .dmem_busy(dmem_busy), .pc_write(a_pcw), .ifid_write(a_ifw),
        .ifid_flush(a_ifl), .idex_bubble(a_bub), .exmem_hold(a_hold), .ctrl_state(a_st),
        .stall_cycles(a_stall), .flush_count(a_fl));

    pipeline_hazard_ctrl #(.REG_AW(AW), .LOAD_USE_STALLS(3), .STALL_CNT_W(5)) dut_b (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .imem_valid(imem_valid), .dmem_busy(dmem_busy), .pc_write(b_pcw), .ifid_write(b_ifw),
        .ifid_flush(b_ifl), .idex_bubble(b_bub), .exmem_hold(b_hold), .ctrl_state(b_st),
        .stall_cycles(b_stall), .flush_count(b_fl));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: owed bubble cycles, memory-wait flag and plain integer counters.
    int     lus[2]  = '{1, 3};
    longint smax[2] = '{65535, 31};
    int     pend[2];
    bit     mw[2];
    longint stc[2];
    int     flc[2];
    bit     known = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step(input int k, output logic [4:0] o, output logic [1:0] st);
        bit haz, fl;
        int np;
        bit nmw;
        haz = ex_mem_read && (ex_rd != 0) &&
              ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
        np  = pend[k];
        nmw = mw[k];
        fl  = 1'b0;
        st  = mw[k] ? 2'd2 : ((pend[k] > 0) ? 2'd1 : 2'd0);
        if (reset) begin
            o = O_RST; np = 0; nmw = 1'b0;
        end else if (pend[k] > 0) begin
            if (ex_branch_taken) begin o = O_FLUSH; np = 0; fl = 1'b1; end
            else if (dmem_busy) o = O_FRZ;
            else begin o = O_BUB; np = pend[k] - 1; end
        end else if (mw[k] && dmem_busy) begin
            o = O_FRZ;
        end else begin
            nmw = 1'b0;
            if (ex_branch_taken) begin o = O_FLUSH; fl = 1'b1; end
            else if (dmem_busy) begin o = O_FRZ; nmw = 1'b1; end
            else if (haz) begin o = O_BUB; np = lus[k] - 1; end
            else if (!imem_valid) o = O_MISS;
            else o = O_RUN;
        end
        if (reset) begin
            stc[k] = 0; flc[k] = 0;
        end else begin
            if (!o[4] && stc[k] < smax[k]) stc[k]++;
            if (fl && flc[k] < 255) flc[k]++;
        end
        pend[k] = np;
        mw[k]   = nmw;
    endtask

    task automatic sample();
        logic [4:0] eo;
        logic [1:0] es;
        longint est;
        int efl;
        bit was_known;
        @(negedge clk);
        was_known = known;
        for (int k = 0; k < 2; k++) begin
            est = stc[k];
            efl = flc[k];
            model_step(k, eo, es);
            chk($sformatf("model_outs_%0d", k), (k == 0) ? a_o : b_o, eo);
            if (was_known) begin
                chk($sformatf("model_state_%0d", k), (k == 0) ? a_st : b_st, es);
                chk($sformatf("model_stall_%0d", k), (k == 0) ? a_stall : b_stall, est);
                chk($sformatf("model_flush_%0d", k), (k == 0) ? a_fl : b_fl, efl);
            end
        end
        if (reset) known = 1'b1;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u,
                          input logic mr, input logic [4:0] rd, input logic br,
                          input logic iv, input logic busy);
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u; ex_mem_read = mr; ex_rd = rd;
        ex_branch_taken = br; imem_valid = iv; dmem_busy = busy;
    endtask

    task automatic set_idle();
        set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_idle();
        cyc();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u, mr;
        logic [4:0] rd;
        logic       br, iv, busy;
        logic [4:0] exp_o;
        logic [1:0] exp_st;
    } vec_t;

    vec_t tbl[14];
    int cnt_stall, cnt_hold;

    initial begin
        for (int k = 0; k < 2; k++) begin pend[k] = 0; mw[k] = 0; stc[k] = 0; flc[k] = 0; end
        // Expected columns describe the single-bubble instance.
        tbl[0]  = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0, O_RUN,   2'd0};
        tbl[1]  = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, O_BUB,   2'd0};
        tbl[2]  = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, O_RUN,   2'd0};
        tbl[3]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, O_RUN,   2'd0};
        tbl[4]  = '{5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, O_RUN,   2'd0};
        tbl[5]  = '{5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, O_BUB,   2'd0};
        tbl[6]  = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, O_MISS,  2'd0};
        tbl[7]  = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 1'b1, O_FRZ,   2'd0};
        tbl[8]  = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 1'b1, O_FRZ,   2'd2};
        tbl[9]  = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, O_RUN,   2'd2};
        tbl[10] = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, O_FLUSH, 2'd0};
        tbl[11] = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_BUB,   2'd0};
        tbl[12] = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, O_FLUSH, 2'd0};
        tbl[13] = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, O_RUN,   2'd0};

        reset = 1'b1;
        set_idle();
        #1;
        sample();
        chk("reset_outs", a_o, O_RST);
        advance();
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            set_in(tbl[i].rs1, tbl[i].rs2, tbl[i].u, tbl[i].mr, tbl[i].rd,
                   tbl[i].br, tbl[i].iv, tbl[i].busy);
            sample();
            chk($sformatf("tbl%0d_outs", i), a_o, tbl[i].exp_o);
            chk($sformatf("tbl%0d_state", i), a_st, tbl[i].exp_st);
            advance();
        end

        // Hazard pulse: three bubbles on the 3-stall instance, one on the other.
        do_reset();
        set_in(5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0);
        sample(); chk("lus3_st0", b_st, 2'd0); chk("lus3_bub0", b_bub, 1'b1); advance();
        set_idle();
        sample(); chk("lus3_st1", b_st, 2'd1); chk("lus3_bub1", b_bub, 1'b1);
        chk("lus1_after", a_o, O_RUN); advance();
        sample(); chk("lus3_st2", b_st, 2'd1); chk("lus3_bub2", b_bub, 1'b1); advance();
        sample(); chk("lus3_st3", b_st, 2'd0); chk("lus3_bub3", b_bub, 1'b0);
        chk("lus1_stall_cnt", a_stall, 16'd1); chk("lus3_stall_cnt", b_stall, 5'd3);
        advance();

        // Memory wait landing on the second load-stall cycle.
        do_reset();
        cnt_stall = 0; cnt_hold = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) set_in(5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0);
            else set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, (i >= 2 && i < 6));
            sample();
            if (!b_pcw) cnt_stall++;
            if (b_hold) cnt_hold++;
            advance();
        end
        chk("memwait_stall_cycles", cnt_stall, 7);
        chk("memwait_hold_cycles", cnt_hold, 4);
        set_idle();
        sample(); chk("memwait_stall_cnt", b_stall, 5'd7); advance();

        // Branch squashes a concurrent hazard.
        do_reset();
        set_in(5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        sample(); chk("br_haz_outs", b_o, O_FLUSH); advance();
        set_idle();
        sample(); chk("br_haz_state", b_st, 2'd0); chk("br_haz_fcnt", b_fl, 8'd1);
        chk("br_haz_fcnt_a", a_fl, 8'd1); advance();

        // Two fetch misses.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
            sample(); chk($sformatf("imiss%0d", i), {a_pcw, a_ifl}, 2'b01); advance();
        end

        // Reset in the middle of a load stall.
        do_reset();
        set_in(5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0);
        cyc();
        set_idle();
        sample(); chk("rst_ls_pre", b_st, 2'd1); advance();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        sample(); chk("rst_ls_state", b_st, 2'd0); chk("rst_ls_stall", b_stall, 5'd0);
        chk("rst_ls_stall_a", a_stall, 16'd0); advance();

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                   1'($urandom), 5'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0));
            cyc();
        end
        reset = 1'b0;

        // Counter saturation.
        do_reset();
        set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65539; i++) cyc();
        sample(); chk("sat_stall_a", a_stall, 16'hFFFF); chk("sat_stall_b", b_stall, 5'h1F);
        advance();
        set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 260; i++) cyc();
        sample(); chk("sat_flush_a", a_fl, 8'hFF); chk("sat_flush_b", b_fl, 8'hFF);
        advance();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage processor.
- Drives the write-enable and flush of the IF/ID register, the PC write enable, the ID/EX bubble and the EX/MEM hold.
- Handles load-use hazards (with a configurable bubble count), taken-branch squash, data-memory wait freezes and instruction-fetch misses.
- Also keeps saturating stall and flush statistics counters.

Parameters:
- REG_AW, 5, register-address width.
- LOAD_USE_STALLS, 1, bubble cycles inserted per load-use hazard. Legal range 1..7.
- STALL_CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- id_rs1  in  REG_AW  source register 1 of the instruction in ID.
- id_rs2  in  REG_AW  source register 2 of the instruction in ID.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  REG_AW  destination register of the EX instruction.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- imem_valid  in  1  fetched instruction is valid this cycle.
- dmem_busy  in  1  data memory not ready; freeze the back end.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  IF/ID loads NOP and zero PC.
- idex_bubble  out  1  ID/EX loads NOP.
- exmem_hold  out  1  EX/MEM and MEM/WB hold.
- ctrl_state  out  2  FSM state: 0 RUN, 1 LOAD_STALL, 2 MEM_WAIT.
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with pc_write=0.
- flush_count  out  8  saturating count of branch flushes.

Behaviour:
- Definition: hazard = ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (id_uses_rs2 & ex_rd == id_rs2)).
- All control outputs are combinational from state and inputs. State, the bubble counter and the statistics counters are registered.
- Reset (cycle where reset=1):
  - Outputs: pc_write=0, ifid_write=1, ifid_flush=1, idex_bubble=1, exmem_hold=0.
  - Next state: state=RUN, bubble counter=0, stall_cycles=0, flush_count=0.
- Reset mid-operation aborts any stall immediately.
- Priority in RUN, highest first:
  1. ex_branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1, exmem_hold=0. Stay in RUN. flush_count+1. The branch squashes any concurrent hazard.
  2. dmem_busy: pc_write=0, ifid_write=0, idex_bubble=0, exmem_hold=1. Next state MEM_WAIT.
  3. hazard: pc_write=0, ifid_write=0, idex_bubble=1. If LOAD_USE_STALLS>1, go to LOAD_STALL and load counter=LOAD_USE_STALLS-1; otherwise stay in RUN.
  4. !imem_valid: pc_write=0, ifid_write=1, ifid_flush=1, idex_bubble=0. Stay in RUN.
  5. Otherwise: pc_write=1, ifid_write=1, all other control outputs 0.
- LOAD_STALL:
  - ex_branch_taken: same outputs as RUN rule 1; next state RUN, counter cleared.
  - Else dmem_busy: freeze outputs as RUN rule 2; stay in LOAD_STALL with counter frozen.
  - Else: pc_write=0, ifid_write=0, idex_bubble=1; decrement counter. Next state RUN when the counter is 1 before decrement.
- MEM_WAIT:
  - dmem_busy=1: freeze outputs as RUN rule 2; stay.
  - dmem_busy=0: evaluate exactly as RUN (rules 1, 3, 4, 5) in the same cycle, including next-state selection.
- Invariants:
  - ifid_flush=1 implies ifid_write=1.
  - exmem_hold=1 implies pc_write=0, ifid_write=0 and idex_bubble=0.
- Statistics: both counters saturate at all-ones and do not wrap. stall_cycles does not count reset cycles.

Test Plan:
- Load-use hazard, LOAD_USE_STALLS=1: ex_mem_read=1, ex_rd=5, id_rs1=5 for one cycle, then ex_mem_read=0 -> exactly one cycle of pc_write=0, ifid_write=0, idex_bubble=1; then normal flow; stall_cycles=1.
- ex_rd=0 with ex_mem_read=1 and id_rs1=0 -> no stall. Case id_rs2=5 with id_uses_rs2=0 -> no stall.
- LOAD_USE_STALLS=3, hazard pulse -> three consecutive bubble cycles, ctrl_state sequence 0,1,1,0.
- dmem_busy asserted for 4 cycles during the second LOAD_STALL cycle -> 4 frozen cycles with exmem_hold=1, then the remaining bubble completes; total 7 cycles with pc_write=0.
- Branch and hazard in the same cycle -> flush only (ifid_flush=1, pc_write=1), no LOAD_STALL entry, flush_count=1.
- imem_valid=0 for 2 cycles -> ifid_flush=1 and pc_write=0 both cycles. Reset asserted during LOAD_STALL -> ctrl_state=0, counters 0 the next cycle.
- Saturation: force 2^STALL_CNT_W+3 stall cycles -> stall_cycles holds at all-ones.
